// File: rtl/util_axis_1553_encoder_param.sv
//----------------------------------------------------------------------------
// util_axis_1553_encoder_param
//
// Purpose:
//   Serialises AXI-Stream words into MIL-STD-1553 style Manchester II frames
//   on a differential pair: a sync pattern, WORD_WIDTH data bits (MSB first),
//   an odd parity bit, then an optional idle gap.
//
// Parameters:
//   CLOCK_SPEED - aclk frequency in Hz
//   BIT_RATE    - encoded bit rate in Hz (CLOCK_SPEED/(2*BIT_RATE) = HALF,
//                 must be an integer >= 2)
//   WORD_WIDTH  - data bits per word (4..32)
//   SYNC_BITS   - sync length in bit times
//   GAP_BITS    - idle bit times after each word (0..15)
//
// Ports:
//   aclk          in   sole clock, rising edge
//   arstn         in   synchronous active-low reset
//   s_axis_tdata  in   word to encode, MSB transmitted first
//   s_axis_tvalid in   word valid
//   s_axis_tuser  in   [0] 1=command/status sync, 0=data sync
//                      [1] parity invert (only with the macro below)
//   s_axis_tready out  high only while IDLE
//   diff          out  [1] positive line, [0] negative line, 2'b00 idle
//
// Optional build macro:
//   UTIL_AXIS_1553_ENCODER_PARITY_INJECT_EN - when defined, a latched
//   tuser[1]=1 inverts the transmitted parity bit (error injection).
//----------------------------------------------------------------------------
module util_axis_1553_encoder_param #(
    parameter int CLOCK_SPEED = 20000000,
    parameter int BIT_RATE    = 1000000,
    parameter int WORD_WIDTH  = 16,
    parameter int SYNC_BITS   = 3,
    parameter int GAP_BITS    = 2
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic [7:0]            s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [1:0]            diff
);

    localparam int HALF     = CLOCK_SPEED / (2 * BIT_RATE);
    localparam int SYNC_CYC = 2 * SYNC_BITS * HALF;
    localparam int BIT_CYC  = 2 * HALF;
    localparam int GAP_CYC  = 2 * HALF * GAP_BITS;
    localparam int CNT_MAX  = (SYNC_CYC > BIT_CYC) ?
                              ((SYNC_CYC > GAP_CYC) ? SYNC_CYC : GAP_CYC) :
                              ((BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC);
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int BIT_W    = $clog2(WORD_WIDTH);

    localparam logic [CNT_W-1:0] SYNC_MID  = CNT_W'(SYNC_CYC / 2);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    // IDLE always emits the final line cycle of a frame (see below), so the
    // state that precedes IDLE stops one cycle short.
    localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'((GAP_BITS == 0) ? (BIT_CYC - 2) : (BIT_CYC - 1));
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS == 0) ? 0 : (GAP_CYC - 2));
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    // Elaboration-time parameter checks
    if ((CLOCK_SPEED % (2 * BIT_RATE)) != 0 || HALF < 2) begin : g_bad_rate
        $error("CLOCK_SPEED/(2*BIT_RATE) must be an integer >= 2");
    end
    if (WORD_WIDTH < 4 || WORD_WIDTH > 32) begin : g_bad_width
        $error("WORD_WIDTH must be in 4..32");
    end
    if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_gap
        $error("GAP_BITS must be in 0..15");
    end
    if (SYNC_BITS < 1) begin : g_bad_sync
        $error("SYNC_BITS must be at least 1");
    end

`ifdef UTIL_AXIS_1553_ENCODER_PARITY_INJECT_EN
    logic       parity_flip;
    logic [5:0] tuser_unused;
    assign parity_flip  = s_axis_tuser[1];
    assign tuser_unused = s_axis_tuser[7:2];
`else
    logic       parity_flip;
    logic [6:0] tuser_unused;
    assign parity_flip  = 1'b0;
    assign tuser_unused = s_axis_tuser[7:1];
`endif

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] shreg;
    logic                  cmd_sync;
    logic                  parity;
    logic [1:0]            tail;

    // Manchester II symbol: a one is high-then-low, a zero low-then-high.
    function automatic logic [1:0] manch(input logic b, input logic first_half);
        if (first_half) begin
            return b ? 2'b10 : 2'b01;
        end
        return b ? 2'b01 : 2'b10;
    endfunction

    // The FSM leads the line by one cycle: the state held during a cycle
    // decides the diff value registered at the following edge. IDLE is
    // entered for the last line cycle of a frame and drives it from 'tail',
    // which lets the accept edge of the next word coincide with that last
    // cycle so back-to-back frames have no extra idle cycle.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state         <= ST_IDLE;
            diff          <= 2'b00;
            s_axis_tready <= 1'b0;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            cmd_sync      <= 1'b0;
            parity        <= 1'b0;
            tail          <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    diff          <= tail;
                    tail          <= 2'b00;
                    s_axis_tready <= 1'b1;
                    if (s_axis_tready && s_axis_tvalid) begin
                        shreg         <= s_axis_tdata;
                        cmd_sync      <= s_axis_tuser[0];
                        parity        <= (~^s_axis_tdata) ^ parity_flip;
                        cnt           <= '0;
                        bit_cnt       <= '0;
                        s_axis_tready <= 1'b0;
                        state         <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (cnt < SYNC_MID) begin
                        diff <= cmd_sync ? 2'b10 : 2'b01;
                    end else begin
                        diff <= cmd_sync ? 2'b01 : 2'b10;
                    end
                    if (cnt == SYNC_LAST) begin
                        cnt   <= '0;
                        state <= ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    diff <= manch(shreg[WORD_WIDTH-1], cnt < HALF_C);
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {shreg[WORD_WIDTH-2:0], 1'b0};
                        if (bit_cnt == WORD_LAST) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_PARITY: begin
                    diff <= manch(parity, cnt < HALF_C);
                    if (cnt == PAR_LAST) begin
                        cnt <= '0;
                        if (GAP_BITS == 0) begin
                            tail          <= manch(parity, 1'b0);
                            s_axis_tready <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    diff <= 2'b00;
                    if (cnt == GAP_LAST) begin
                        cnt           <= '0;
                        tail          <= 2'b00;
                        s_axis_tready <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    diff          <= 2'b00;
                    s_axis_tready <= 1'b0;
                    cnt           <= '0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_util_axis_1553_encoder_param.sv
//----------------------------------------------------------------------------
// tb_util_axis_1553_encoder_param
//
// Directed bench for util_axis_1553_encoder_param. Instance dut_a uses the
// default parameters (16-bit words, 2-bit gap, 440-cycle word period);
// dut_b uses WORD_WIDTH=8, GAP_BITS=0 (240-cycle word period). Both run at
// HALF=10 clocks per half bit.
//----------------------------------------------------------------------------
module tb_util_axis_1553_encoder_param;

    logic        tb_data_clk;
    logic        arstn;

    logic [15:0] tdata_a;
    logic        tvalid_a;
    logic [7:0]  tuser_a;
    logic        tready_a;
    logic [1:0]  diff_a;

    logic [7:0]  tdata_b;
    logic        tvalid_b;
    logic [7:0]  tuser_b;
    logic        tready_b;
    logic [1:0]  diff_b;

    int vectors;
    int miscompares;

`ifdef UTIL_AXIS_1553_ENCODER_PARITY_INJECT_EN
    localparam logic PAR_INJ = 1'b0;
`else
    localparam logic PAR_INJ = 1'b1;
`endif

    util_axis_1553_encoder_param #(
        .CLOCK_SPEED (20000000),
        .BIT_RATE    (1000000),
        .WORD_WIDTH  (16),
        .SYNC_BITS   (3),
        .GAP_BITS    (2)
    ) dut_a (
        .aclk          (tb_data_clk),
        .arstn         (arstn),
        .s_axis_tdata  (tdata_a),
        .s_axis_tvalid (tvalid_a),
        .s_axis_tuser  (tuser_a),
        .s_axis_tready (tready_a),
        .diff          (diff_a)
    );

    util_axis_1553_encoder_param #(
        .CLOCK_SPEED (20000000),
        .BIT_RATE    (1000000),
        .WORD_WIDTH  (8),
        .SYNC_BITS   (3),
        .GAP_BITS    (0)
    ) dut_b (
        .aclk          (tb_data_clk),
        .arstn         (arstn),
        .s_axis_tdata  (tdata_b),
        .s_axis_tvalid (tvalid_b),
        .s_axis_tuser  (tuser_b),
        .s_axis_tready (tready_b),
        .diff          (diff_b)
    );

    initial tb_data_clk = 1'b0;
    always #5 tb_data_clk = ~tb_data_clk;

    // Expected line value for frame cycle idx (0 = first sync cycle),
    // HALF=10, SYNC_BITS=3; anything after the parity bit is idle.
    function automatic logic [1:0] exp_line(input logic cmd, input logic [31:0] word,
                                            input int width, input logic par, input int idx);
        int   j;
        logic b;
        if (idx < 30) return cmd ? 2'b10 : 2'b01;
        if (idx < 60) return cmd ? 2'b01 : 2'b10;
        j = idx - 60;
        if (j < 20 * width) b = word[width - 1 - j / 20];
        else if (j < 20 * width + 20) b = par;
        else return 2'b00;
        if ((j % 20) < 10) return b ? 2'b10 : 2'b01;
        return b ? 2'b01 : 2'b10;
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_check(input bit sel, input logic [1:0] ed, input logic et, input string tag);
        @(posedge tb_data_clk);
        #1;
        chk({30'd0, sel ? diff_b : diff_a}, {30'd0, ed}, {tag, " diff"});
        chk({31'd0, sel ? tready_b : tready_a}, {31'd0, et}, {tag, " tready"});
    endtask

    // Checks edges p=from..upto after the accept edge; tready is expected
    // high only after edge total-1, i.e. one cycle ahead of the next accept.
    task automatic check_frame(input bit sel, input logic cmd, input logic [31:0] word,
                               input int width, input logic par, input int total,
                               input int from, input int upto);
        for (int p = from; p <= upto; p++) begin
            step_check(sel, exp_line(cmd, word, width, par, p - 1), (p == total - 1),
                       $sformatf("frame%0d p=%0d", sel, p));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        arstn    = 1'b0;
        tdata_a  = '0; tvalid_a = 1'b0; tuser_a = '0;
        tdata_b  = '0; tvalid_b = 1'b0; tuser_b = '0;

        // Reset: two cycles low, then release
        repeat (2) begin
            step_check(1'b0, 2'b00, 1'b0, "rst a");
            step_check(1'b1, 2'b00, 1'b0, "rst b");
        end
        arstn = 1'b1;
        @(posedge tb_data_clk);
        #1;
        chk({31'd0, tready_a}, 32'd1, "release tready_a");
        chk({31'd0, tready_b}, 32'd1, "release tready_b");
        chk({30'd0, diff_a},   32'd0, "release diff_a");

        // Command sync, word 0000 -> parity 1, then 40-cycle gap
        tdata_a = 16'h0000; tuser_a = 8'h01; tvalid_a = 1'b1;
        step_check(1'b0, 2'b00, 1'b0, "accept 0000");
        tvalid_a = 1'b0;
        check_frame(1'b0, 1'b1, 32'h0000, 16, 1'b1, 440, 1, 439);
        step_check(1'b0, 2'b00, 1'b1, "gap end 0000");
        step_check(1'b0, 2'b00, 1'b1, "idle after 0000");

        // Back-to-back data-sync words FFFF then 0000 with tvalid held;
        // tdata wiggles mid-frame must not reach the word in flight
        tdata_a = 16'hFFFF; tuser_a = 8'h00; tvalid_a = 1'b1;
        step_check(1'b0, 2'b00, 1'b0, "accept ffff");
        check_frame(1'b0, 1'b0, 32'hFFFF, 16, 1'b1, 440, 1, 100);
        tdata_a = 16'h5A5A;
        check_frame(1'b0, 1'b0, 32'hFFFF, 16, 1'b1, 440, 101, 300);
        tdata_a = 16'h0000;
        check_frame(1'b0, 1'b0, 32'hFFFF, 16, 1'b1, 440, 301, 439);
        step_check(1'b0, 2'b00, 1'b0, "reaccept 0000");
        check_frame(1'b0, 1'b0, 32'h0000, 16, 1'b1, 440, 1, 200);
        tvalid_a = 1'b0;
        check_frame(1'b0, 1'b0, 32'h0000, 16, 1'b1, 440, 201, 439);
        step_check(1'b0, 2'b00, 1'b1, "idle after pair");

        // Parity inject request on an all-ones word
        tdata_a = 16'hFFFF; tuser_a = 8'h02; tvalid_a = 1'b1;
        step_check(1'b0, 2'b00, 1'b0, "accept inj");
        tvalid_a = 1'b0;
        check_frame(1'b0, 1'b0, 32'hFFFF, 16, PAR_INJ, 440, 1, 439);
        step_check(1'b0, 2'b00, 1'b1, "idle after inj");

        // Reset 150 cycles into a frame (word 1234 has 5 ones -> parity 0)
        tdata_a = 16'h1234; tuser_a = 8'h01; tvalid_a = 1'b1;
        step_check(1'b0, 2'b00, 1'b0, "accept 1234");
        tvalid_a = 1'b0;
        check_frame(1'b0, 1'b1, 32'h1234, 16, 1'b0, 440, 1, 150);
        arstn = 1'b0;
        step_check(1'b0, 2'b00, 1'b0, "midframe rst");
        step_check(1'b0, 2'b00, 1'b0, "midframe rst hold");
        arstn = 1'b1;
        step_check(1'b0, 2'b00, 1'b1, "midframe release");
        repeat (20) step_check(1'b0, 2'b00, 1'b1, "no residual");

        // 8-bit, no-gap instance: A5 (bits 1,0,1,0,0,1,0,1, parity 1) then 3C
        tdata_b = 8'hA5; tuser_b = 8'h00; tvalid_b = 1'b1;
        step_check(1'b1, 2'b00, 1'b0, "accept a5");
        check_frame(1'b1, 1'b0, 32'hA5, 8, 1'b1, 240, 1, 50);
        tdata_b = 8'h3C;
        check_frame(1'b1, 1'b0, 32'hA5, 8, 1'b1, 240, 51, 239);
        step_check(1'b1, 2'b01, 1'b0, "reaccept 3c");
        tvalid_b = 1'b0;
        check_frame(1'b1, 1'b0, 32'h3C, 8, 1'b1, 240, 1, 239);
        step_check(1'b1, 2'b01, 1'b1, "parity tail 3c");
        step_check(1'b1, 2'b00, 1'b1, "idle b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/util_axis_1553_encoder_param.md
UTIL_AXIS_1553_ENCODER_PARAM -- requirements
Module: util_axis_1553_encoder_param

Interface
REQ-001 SHALL have parameter CLOCK_SPEED, default 20000000, aclk frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 1000000, encoded bit rate in Hz.
REQ-003 SHALL have parameter WORD_WIDTH, default 16, data bits per word (range 4..32).
REQ-004 SHALL have parameter SYNC_BITS, default 3, sync length in bit times (even half-bit split, 1.5/1.5 for 3).
REQ-005 SHALL have parameter GAP_BITS, default 2, idle bit times after each word (range 0..15).
REQ-006 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port arstn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port s_axis_tdata  input  WORD_WIDTH  word to encode, MSB sent first.
REQ-009 SHALL have port s_axis_tvalid  input  1  word valid.
REQ-010 SHALL have port s_axis_tuser  input  8  [0]=1 command/status sync, 0 data sync; [1] parity invert (see Configuration); [7:2] ignored.
REQ-011 SHALL have port s_axis_tready  output  1  block can accept a word.
REQ-012 SHALL have port diff  output  2  [1] positive line, [0] negative line; 2'b00 idle.

Function
REQ-013 SHALL compute HALF = CLOCK_SPEED/(2*BIT_RATE); non-integer or HALF<2 SHALL be a elaboration error.
REQ-014 SHALL implement states IDLE, SYNC, DATA, PARITY, GAP; IDLE->SYNC on tvalid&&tready, SYNC->DATA, DATA->PARITY after WORD_WIDTH bits, PARITY->GAP, GAP->IDLE (GAP skipped if GAP_BITS=0).
REQ-015 SHALL assert s_axis_tready only in IDLE; transfer when tvalid&&tready on a rising edge; tdata/tuser latched that edge.
REQ-016 SHALL drive first sync half-bit on the edge after the accepting edge (latency 1 cycle).
REQ-017 Command sync SHALL be diff=2'b10 for SYNC_BITS*HALF cycles then 2'b01 for SYNC_BITS*HALF cycles; data sync SHALL be the inverse order.
REQ-018 Each data bit SHALL be Manchester II: 1 = 2'b10 for HALF cycles then 2'b01 for HALF; 0 = 2'b01 then 2'b10.
REQ-019 Parity bit SHALL be odd parity over the latched word (ones in word+parity odd), encoded per REQ-018.
REQ-020 GAP SHALL drive 2'b00 for GAP_BITS*2*HALF cycles.
REQ-021 diff SHALL never be 2'b11; diff SHALL be registered (no combinational path from inputs).
REQ-022 Frame length SHALL be (2*SYNC_BITS + 2*WORD_WIDTH + 2)*HALF cycles; tready SHALL reassert frame+gap cycles after accept.
REQ-023 tvalid held high with tready low SHALL not affect the word in flight; tdata changes while not accepted SHALL be ignored.
REQ-024 Counters SHALL be sized by clog2 of their maximum; no wrap-around within a frame.

Reset
REQ-025 While arstn=0 at a rising edge: state=IDLE, diff=2'b00, s_axis_tready=0, counters and shift register cleared.
REQ-026 First edge with arstn=1 SHALL set s_axis_tready=1; reset mid-frame SHALL discard the word with diff=2'b00 at the next edge.

Configuration
REQ-027 Macro UTIL_AXIS_1553_ENCODER_PARITY_INJECT_EN, when defined, SHALL invert the transmitted parity bit when latched tuser[1]=1.
REQ-028 Without the macro, tuser[1] SHALL be ignored and parity always odd.

Verification (CLOCK_SPEED=20000000, BIT_RATE=1000000, HALF=10, defaults unless stated)
REQ-029 arstn low 2 cycles then high -> diff=00, tready=0 during reset; tready=1 first edge after release.
REQ-030 tdata=16'h0000, tuser=8'h01 -> diff=10 for 30 cycles, 01 for 30, 16x(01 10 cycles, 10 10 cycles), parity 10/01, then 00 for 40 cycles.
REQ-031 tvalid held high, tdata incrementing from 16'hFFFF -> tready pulses every 440 cycles; consecutive sync starts 440 cycles apart; words 16'hFFFF, 16'h0000 sent in order.
REQ-032 arstn low at cycle 150 of a frame -> diff=00 next edge, tready=1 after release, no residual bits.
REQ-033 tdata=16'hFFFF, tuser=8'h02: with macro -> parity bit encodes 0; without macro -> parity bit encodes 1.
REQ-034 WORD_WIDTH=8, GAP_BITS=0, tdata=8'hA5, tuser=8'h00 -> data sync (01 then 10), bits 1,0,1,0,0,1,0,1, parity 1, frame 240 cycles, tready reasserts 240 cycles after accept.
